// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encodings and the BCD digit width.
package bcd_convert_ctrl_pkg;

  localparam int unsigned BcdDigitW = 4;

  // Code 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Request/result bundle between a requester (master) and the BCD converter (slave).
interface bcd_convert_ctrl_if
  import bcd_convert_ctrl_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          busy;
  logic                          done;
  logic [BcdDigitW*DIGITS-1:0]   bcd_out;
  logic                          ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );

endinterface

// File: rtl/bcd_convert_ctrl_add3.sv
// Per-digit corrector for shift-and-add-3: digits of 5 or more get +3 before the shift.
module bcd_convert_ctrl_add3
  import bcd_convert_ctrl_pkg::*;
(
  input  logic [BcdDigitW-1:0] i_digit,
  output logic [BcdDigitW-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter: one shift per cycle for BIN_W cycles, then a done pulse
// with registered packed BCD and an overflow flag.
module bcd_convert_ctrl
  import bcd_convert_ctrl_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  bcd_convert_ctrl_if.slave bus
);

  localparam int unsigned BcdW = BcdDigitW * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W);
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

  state_e            r_state;
  logic [BIN_W-1:0]  r_bin;
  logic [BcdW-1:0]   r_bcd;
  logic [CntW-1:0]   r_cnt;
  logic              r_ovf_acc;
  logic              r_busy;
  logic              r_done;
  logic [BcdW-1:0]   r_bcd_out;
  logic              r_ovf;

  logic [BcdW-1:0]   w_corr;
  logic [BcdW-1:0]   w_bcd_nxt;
  logic              w_ovf_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_convert_ctrl_add3 u_add3 (
      .i_digit (r_bcd[g*BcdDigitW +: BcdDigitW]),
      .o_digit (w_corr[g*BcdDigitW +: BcdDigitW])
    );
  end

  // Corrected accumulator shifted left with the next binary MSB; the bit leaving the top digit
  // means the value does not fit in DIGITS digits.
  assign w_bcd_nxt = {w_corr[BcdW-2:0], r_bin[BIN_W-1]};
  assign w_ovf_nxt = r_ovf_acc | w_corr[BcdW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_bin     <= bus.bin_in;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= StShift;
          end
        end
        StShift: begin
          r_bcd     <= w_bcd_nxt;
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_ovf_acc <= w_ovf_nxt;
          if (r_cnt == CntLast) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_bcd_out <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
            r_state   <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd_out;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Scoreboard bench for bcd_convert_ctrl: 8-bit/3-digit and 8-bit/2-digit instances.
module tb_bcd_convert_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  bcd_convert_ctrl_if #(.BIN_W(8), .DIGITS(3)) if_a ();
  bcd_convert_ctrl_if #(.BIN_W(8), .DIGITS(2)) if_b ();

  bcd_convert_ctrl #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a)
  );

  bcd_convert_ctrl #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {ovf, bcd_out} per instance.
  logic [12:0] q_a[$];
  logic [8:0]  q_b[$];
  logic [12:0] e_a;
  logic [8:0]  e_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_a.done === 1'b1) begin
      check("a_busy_low_on_done", 32'(if_a.busy), 32'd0);
      if (q_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_done: got done with bcd=%h, required no done", if_a.bcd_out);
      end else begin
        e_a = q_a.pop_front();
        check("a_bcd_out", 32'(if_a.bcd_out), 32'(e_a[11:0]));
        check("a_ovf", 32'(if_a.ovf), 32'(e_a[12]));
      end
    end
    if (if_b.done === 1'b1) begin
      check("b_busy_low_on_done", 32'(if_b.busy), 32'd0);
      if (q_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_done: got done with bcd=%h, required no done", if_b.bcd_out);
      end else begin
        e_b = q_b.pop_front();
        check("b_bcd_out", 32'(if_b.bcd_out), 32'(e_b[7:0]));
        check("b_ovf", 32'(if_b.ovf), 32'(e_b[8]));
      end
    end
  end

  task automatic set_start(input bit which, input logic s, input logic [7:0] v);
    if (which) begin
      if_b.start  = s;
      if_b.bin_in = v;
    end else begin
      if_a.start  = s;
      if_a.bin_in = v;
    end
  endtask

  // One conversion; optional extra start pulses while busy must be ignored.
  task automatic run(input bit which, input logic [7:0] v, input bit extra);
    int  n;
    int  bc;
    bit  got;
    logic d;
    logic b;
    @(negedge clk);
    set_start(which, 1'b1, v);
    @(negedge clk);
    set_start(which, 1'b0, 8'hxx);
    n   = 0;
    bc  = 0;
    got = 0;
    while (n < 20 && !got) begin
      d = which ? if_b.done : if_a.done;
      b = which ? if_b.busy : if_a.busy;
      if (d === 1'b1) begin
        got = 1;
      end else begin
        if (b === 1'b1) bc++;
        set_start(which, (extra && (n == 2 || n == 5)) ? 1'b1 : 1'b0, 8'd77);
        @(negedge clk);
        n++;
      end
    end
    set_start(which, 1'b0, 8'h00);
    check("done_seen", 32'(got), 32'd1);
    check("done_latency", 32'(n), 32'd8);
    check("busy_cycles", 32'(bc), 32'd8);
  endtask

  int  t_prev;
  int  nw;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_start(1'b0, 1'b0, 8'h00);
    set_start(1'b1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("rst_a_busy", 32'(if_a.busy), 32'd0);
    check("rst_a_done", 32'(if_a.done), 32'd0);
    check("rst_a_bcd", 32'(if_a.bcd_out), 32'd0);
    check("rst_a_ovf", 32'(if_a.ovf), 32'd0);
    check("rst_b_bcd", 32'(if_b.bcd_out), 32'd0);
    check("rst_b_busy", 32'(if_b.busy), 32'd0);

    q_a.push_back({1'b0, 12'h000}); run(1'b0, 8'd0, 1'b0);
    q_a.push_back({1'b0, 12'h255}); run(1'b0, 8'd255, 1'b0);
    q_a.push_back({1'b0, 12'h099}); run(1'b0, 8'd99, 1'b0);
    q_a.push_back({1'b0, 12'h009}); run(1'b0, 8'd9, 1'b0);
    q_a.push_back({1'b0, 12'h128}); run(1'b0, 8'd128, 1'b1);
    repeat (12) @(negedge clk);
    check("a_held_after_done", 32'(if_a.bcd_out), 32'h128);

    // Abort a conversion of 200 with reset; no done may follow.
    @(negedge clk);
    set_start(1'b0, 1'b1, 8'd200);
    @(negedge clk);
    set_start(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("abort_busy", 32'(if_a.busy), 32'd0);
    check("abort_done", 32'(if_a.done), 32'd0);
    repeat (12) @(negedge clk);
    q_a.push_back({1'b0, 12'h042}); run(1'b0, 8'd42, 1'b0);

    q_b.push_back({1'b1, 8'h00}); run(1'b1, 8'd200, 1'b0);
    q_b.push_back({1'b0, 8'h57}); run(1'b1, 8'd57, 1'b0);
    q_b.push_back({1'b1, 8'h00}); run(1'b1, 8'd100, 1'b0);
    q_b.push_back({1'b0, 8'h99}); run(1'b1, 8'd99, 1'b0);

    // Start held high: one conversion every 10 cycles.
    q_a.push_back({1'b0, 12'h001});
    q_a.push_back({1'b0, 12'h002});
    q_a.push_back({1'b0, 12'h003});
    @(negedge clk);
    set_start(1'b0, 1'b1, 8'd1);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      nw = 0;
      @(negedge clk);
      while (if_a.done !== 1'b1 && nw < 30) begin
        @(negedge clk);
        nw++;
      end
      check("b2b_done_seen", 32'(if_a.done), 32'd1);
      if (k > 0) check("b2b_period", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
      set_start(1'b0, 1'b1, 8'(k + 2));
    end
    set_start(1'b0, 1'b0, 8'h00);

    repeat (15) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
